// File: rtl/ysyx_23060025_mem_arbiter_if.sv
// Bus bundle for the IFU/LSU memory arbiter: both requester ports plus the
// shared downstream memory port. "slave" is the arbiter's view.
interface ysyx_23060025_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    ifu_psel;
    logic [ADDR_WIDTH-1:0]   ifu_paddr;
    logic                    ifu_pready;
    logic [DATA_WIDTH-1:0]   ifu_prdata;

    logic                    lsu_psel;
    logic                    lsu_pwrite;
    logic [ADDR_WIDTH-1:0]   lsu_paddr;
    logic [DATA_WIDTH-1:0]   lsu_pwdata;
    logic [DATA_WIDTH/8-1:0] lsu_pstrb;
    logic                    lsu_pready;
    logic [DATA_WIDTH-1:0]   lsu_prdata;

    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_wen;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  ifu_psel, ifu_paddr,
        input  lsu_psel, lsu_pwrite, lsu_paddr, lsu_pwdata, lsu_pstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output ifu_pready, ifu_prdata,
        output lsu_pready, lsu_prdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb
    );

    modport master (
        output ifu_psel, ifu_paddr,
        output lsu_psel, lsu_pwrite, lsu_paddr, lsu_pwdata, lsu_pstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  ifu_pready, ifu_prdata,
        input  lsu_pready, lsu_prdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/ysyx_23060025_mem_arbiter.sv
// IFU/LSU arbiter onto one memory port, one outstanding transaction at a time.
// Define ARB_RR_EN for round-robin tie breaking; default is fixed LSU priority.
module ysyx_23060025_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic                       clock,
    input logic                       reset,
    ysyx_23060025_mem_arbiter_if.slave bus
);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [SW-1:0]         r_wstrb;
    logic [DATA_WIDTH-1:0] r_ifu_rdata;
    logic [DATA_WIDTH-1:0] r_lsu_rdata;

    logic w_grant;
    logic w_rsp;
    logic w_pick_lsu;
    logic w_ifu_done;
    logic w_lsu_done;

`ifdef ARB_RR_EN
    logic r_last_owner;

    // On a tie the requester that lost the previous grant goes first.
    assign w_pick_lsu = bus.lsu_psel & (~bus.ifu_psel | ~r_last_owner);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_owner <= 1'b1;
        end else if (w_grant) begin
            r_last_owner <= w_pick_lsu;
        end
    end
`else
    assign w_pick_lsu = bus.lsu_psel;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_rsp   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.ifu_psel | bus.lsu_psel) begin
                    w_grant = 1'b1;
                    w_next  = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    w_next = RSP;
                end
            end
            RSP: begin
                if (bus.mem_rsp_valid) begin
                    w_rsp  = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Request fields are captured once at grant and ignored afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_grant) begin
            r_owner <= w_pick_lsu;
            r_addr  <= w_pick_lsu ? bus.lsu_paddr : bus.ifu_paddr;
            r_wen   <= w_pick_lsu & bus.lsu_pwrite;
            r_wdata <= w_pick_lsu ? bus.lsu_pwdata : '0;
            r_wstrb <= w_pick_lsu ? bus.lsu_pstrb : '0;
        end
    end

    assign w_ifu_done = w_rsp & ~r_owner;
    assign w_lsu_done = w_rsp & r_owner;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ifu_rdata <= '0;
            r_lsu_rdata <= '0;
        end else begin
            if (w_ifu_done) begin
                r_ifu_rdata <= bus.mem_rdata;
            end
            if (w_lsu_done) begin
                r_lsu_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req_valid = (r_state == REQ);
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wen       = r_wen;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_wstrb     = r_wstrb;

    assign bus.ifu_pready = w_ifu_done;
    assign bus.lsu_pready = w_lsu_done;
    assign bus.ifu_prdata = w_ifu_done ? bus.mem_rdata : r_ifu_rdata;
    assign bus.lsu_prdata = w_lsu_done ? bus.mem_rdata : r_lsu_rdata;
endmodule
